// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding, length codes and beat-count helper for mem_arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MemArbIdle,
    MemArbIfRd,
    MemArbMemRd,
    MemArbMemWr,
    MemArbDone
  } arb_state_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_e;

  localparam logic [1:0] MemLenByte = 2'b00;
  localparam logic [1:0] MemLenHalf = 2'b01;
  localparam logic [1:0] MemLenWord = 2'b10;

  // Index of the final byte beat; code 11 behaves as a word.
  function automatic logic [1:0] last_beat(input logic [1:0] len);
    case (len)
      MemLenByte: return 2'd0;
      MemLenHalf: return 2'd1;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_bytepack.sv
// Byte-lane helper: picks the store byte for a lane and merges a read byte into its lane.
module mem_arbiter_bytepack
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  i_wlane,
  input  logic [31:0] i_wdata,
  output logic [7:0]  o_wbyte,
  input  logic [1:0]  i_rlane,
  input  logic [31:0] i_acc,
  input  logic [7:0]  i_rbyte,
  output logic [31:0] o_acc
);

  always_comb begin
    o_wbyte = '0;
    case (i_wlane)
      2'd0:    o_wbyte = i_wdata[7:0];
      2'd1:    o_wbyte = i_wdata[15:8];
      2'd2:    o_wbyte = i_wdata[23:16];
      default: o_wbyte = i_wdata[31:24];
    endcase
  end

  always_comb begin
    o_acc = i_acc;
    case (i_rlane)
      2'd0:    o_acc[7:0]   = i_rbyte;
      2'd1:    o_acc[15:8]  = i_rbyte;
      2'd2:    o_acc[23:16] = i_rbyte;
      default: o_acc[31:24] = i_rbyte;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the MEM stage.
// Optional MEMARB_FAIR_EN: alternate grants when both requesters are pending.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  arb_state_e  r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [31:0] r_acc;
  logic        w_grant_mem;
  logic [1:0]  w_wlane;
  logic [7:0]  w_wbyte;
  logic [31:0] w_acc;

  assign stallreq_if_o  = if_req_i & ~if_done_o;
  assign stallreq_mem_o = mem_req_i & ~mem_done_o;

`ifdef MEMARB_FAIR_EN
  grant_e r_last_grant;

  assign w_grant_mem = mem_req_i & (~if_req_i | (r_last_grant == GrantIf));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GrantIf;
    end else if (r_state == MemArbIdle && (mem_req_i || if_req_i)) begin
      r_last_grant <= w_grant_mem ? GrantMem : GrantIf;
    end
  end
`else
  assign w_grant_mem = mem_req_i;
`endif

  // Store byte for the beat being issued next: lane 0 on grant, cnt+1 afterwards.
  assign w_wlane = (r_state == MemArbIdle) ? 2'd0 : r_cnt + 2'd1;

  mem_arbiter_bytepack u_bytepack (
    .i_wlane (w_wlane),
    .i_wdata (mem_wdata_i),
    .o_wbyte (w_wbyte),
    .i_rlane (r_cnt),
    .i_acc   (r_acc),
    .i_rbyte (ram_din_i),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MemArbIdle;
      r_cnt       <= '0;
      r_last      <= '0;
      r_acc       <= '0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_dout_o  <= '0;
      if_data_o   <= '0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (r_state)
        MemArbIdle: begin
          r_cnt <= '0;
          r_acc <= '0;
          if (w_grant_mem) begin
            r_last     <= last_beat(mem_len_i);
            ram_addr_o <= mem_addr_i[ADDR_W-1:0];
            if (mem_we_i) begin
              r_state    <= MemArbMemWr;
              ram_we_o   <= 1'b1;
              ram_dout_o <= w_wbyte;
              mem_done_o <= (last_beat(mem_len_i) == 2'd0);
            end else begin
              r_state <= MemArbMemRd;
            end
          end else if (if_req_i) begin
            r_state    <= MemArbIfRd;
            r_last     <= 2'd3;
            ram_addr_o <= if_addr_i[ADDR_W-1:0];
          end
        end
        // Store completion is flagged together with the final beat, one cycle
        // earlier than a read of the same length.
        MemArbMemWr: begin
          if (r_cnt == r_last) begin
            r_state  <= MemArbDone;
            ram_we_o <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 2'd1;
            ram_addr_o <= ram_addr_o + ADDR_W'(1);
            ram_dout_o <= w_wbyte;
            mem_done_o <= ((r_cnt + 2'd1) == r_last);
          end
        end
        MemArbIfRd, MemArbMemRd: begin
          if (r_state == MemArbIfRd && !if_req_i) begin
            r_state <= MemArbIdle;
          end else if (r_cnt == r_last) begin
            r_state <= MemArbDone;
            if (r_state == MemArbIfRd) begin
              if_data_o <= w_acc;
              if_done_o <= 1'b1;
            end else begin
              mem_rdata_o <= w_acc;
              mem_done_o  <= 1'b1;
            end
          end else begin
            r_acc      <= w_acc;
            r_cnt      <= r_cnt + 2'd1;
            ram_addr_o <= ram_addr_o + ADDR_W'(1);
          end
        end
        MemArbDone: r_state <= MemArbIdle;
        default:    r_state <= MemArbIdle;
      endcase
    end
  end

endmodule
